// File: rtl/processor_instr_issuer.sv
// Host-side feeder for the 9-bit processor: queues host words and issues one
// instruction at a time on DataIn/Run, waits for Done, flags a sticky timeout.
module processor_instr_issuer #(
  parameter int          DEPTH      = 4,
  parameter logic [2:0]  MVI_OPCODE = 3'b001,
  parameter int          TIMEOUT    = 15
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       InValid,
  input  logic [8:0] InWord,
  output logic       InReady,
  input  logic       Enable,
  output logic [8:0] DataIn,
  output logic       Run,
  input  logic       Done,
  output logic       Busy,
  output logic [7:0] IssueCount,
  output logic       Error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [7:0]    TMR_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [8:0]      data_q, data_d;
  logic            run_q, run_d;
  logic            busy_q, busy_d;
  logic [7:0]      issued_q, issued_d;
  logic            err_q, err_d;
  logic [7:0]      timer_q, timer_d;

  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic [8:0]      head_s;
  logic            head_is_mvi_s;
  logic            ready_s;

  assign full_s        = (count_q == CNT_FULL);
  assign push_s        = InValid && !full_s;
  assign head_s        = mem_q[rd_ptr_q];
  assign head_is_mvi_s = (head_s[8:6] == MVI_OPCODE);
  // Readiness uses the registered count, so a word pushed this cycle cannot be popped yet.
  assign ready_s       = head_is_mvi_s ? (count_q >= CNT_TWO) : (count_q >= CNT_ONE);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    run_d    = 1'b0;
    busy_d   = busy_q;
    issued_d = issued_q;
    err_d    = err_q;
    timer_d  = timer_q;
    pop_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Enable && ready_s) begin
          pop_s   = 1'b1;
          data_d  = head_s;
          run_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        busy_d  = 1'b1;
        state_d = S_WAIT;
        // The mvi immediate is guaranteed present: IDLE only starts an mvi with two words queued.
        if ((data_q[8:6] == MVI_OPCODE) && (count_q != CNT_ZERO)) begin
          pop_s  = 1'b1;
          data_d = head_s;
        end else begin
          pop_s  = 1'b0;
        end
      end
      S_WAIT: begin
        if (Done) begin
          issued_d = issued_q + 8'd1;
          timer_d  = 8'd0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          err_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_HALT;
        end else begin
          timer_d  = timer_q + 8'd1;
        end
      end
      S_HALT: begin
        busy_d  = 1'b0;
        state_d = S_HALT;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= 9'd0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      issued_q <= 8'd0;
      err_q    <= 1'b0;
      timer_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      issued_q <= issued_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= InWord;
    end
  end

  assign InReady    = !full_s;
  assign DataIn     = data_q;
  assign Run        = run_q;
  assign Busy       = busy_q;
  assign IssueCount = issued_q;
  assign Error      = err_q;

endmodule

// File: tb/tb_processor_instr_issuer.sv
// Directed bench for processor_instr_issuer: a scoreboard queue holds every
// pushed host word and is popped as the DUT presents words on DataIn.
module tb_processor_instr_issuer;

  logic       clock = 1'b0;
  logic       Reset;
  logic       InValid;
  logic [8:0] InWord;
  logic       InReady;
  logic       Enable;
  logic [8:0] DataIn;
  logic       Run;
  logic       Done;
  logic       Busy;
  logic [7:0] IssueCount;
  logic       Error;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [8:0] exp_q [$];
  logic [7:0] model_cnt = 8'd0;

  always #5 clock = ~clock;

  processor_instr_issuer #(
    .DEPTH(4), .MVI_OPCODE(3'b001), .TIMEOUT(15)
  ) dut (
    .clock(clock), .Reset(Reset), .InValid(InValid), .InWord(InWord),
    .InReady(InReady), .Enable(Enable), .DataIn(DataIn), .Run(Run),
    .Done(Done), .Busy(Busy), .IssueCount(IssueCount), .Error(Error)
  );

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [8:0] w);
    InValid = 1'b1;
    InWord  = w;
    exp_q.push_back(w);
    tick();
    InValid = 1'b0;
  endtask

  task automatic pop_exp(output logic [8:0] w);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      w = 9'd0;
    end else begin
      w = exp_q.pop_front();
    end
  endtask

  // Wait for a Run pulse and compare the issued instruction against the scoreboard.
  task automatic wait_run(input int budget, input int exp_lat, output logic [8:0] ins, output int run_cyc);
    int waited;
    waited = 0;
    while (Run !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    chk("run_seen", Run, 1);
    if (exp_lat >= 0) chk("run_latency", waited, exp_lat);
    pop_exp(ins);
    chk("run_datain", DataIn, ins);
    chk("run_busy", Busy, 1);
    run_cyc = cyc;
  endtask

  // Full instruction: Run, d WAIT cycles, Done asserted in the d-th WAIT cycle.
  task automatic issue(input int d, input int exp_lat, input logic drop_en, output int run_cyc);
    logic [8:0] ins;
    logic [8:0] hold;
    wait_run(40, exp_lat, ins, run_cyc);
    if (drop_en) Enable = 1'b0;
    hold = ins;
    for (int i = 1; i <= d; i++) begin
      tick();
      if (i == 1 && ins[8:6] == 3'b001) pop_exp(hold);
      chk("wait_run_low", Run, 0);
      chk("wait_datain", DataIn, hold);
      chk("wait_busy", Busy, 1);
      chk("wait_error", Error, 0);
      if (i == d) Done = 1'b1;
    end
    tick();
    Done = 1'b0;
    model_cnt = model_cnt + 8'd1;
    chk("done_count", IssueCount, model_cnt);
    chk("done_busy", Busy, 0);
    chk("done_run", Run, 0);
  endtask

  initial begin
    logic [8:0] ins;
    int rc, prev_rc;
    Reset = 1'b1; InValid = 1'b0; InWord = 9'd0; Enable = 1'b0; Done = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    chk("rst_datain", DataIn, 0);
    chk("rst_run", Run, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_count", IssueCount, 0);
    chk("rst_error", Error, 0);
    chk("rst_inready", InReady, 1);
    tick();
    chk("rst_inready_after", InReady, 1);

    // Single instruction, Enable dropped mid-flight must not abort it.
    Enable = 1'b1;
    push(9'o012);
    issue(3, 1, 1'b1, rc);
    tick();
    chk("single_no_rerun", Run, 0);

    // mvi needs both words before issuing.
    Enable = 1'b1;
    push(9'o100);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mvi_hold_run", Run, 0);
      chk("mvi_hold_busy", Busy, 0);
    end
    push(9'h0A5);
    issue(3, 1, 1'b0, rc);

    // Back-to-back: fill the FIFO, a push while full is dropped.
    Enable = 1'b0;
    push(9'o210); push(9'o321); push(9'o432); push(9'o543);
    chk("full_inready", InReady, 0);
    InValid = 1'b1; InWord = 9'o777;
    tick();
    InValid = 1'b0;
    chk("full_inready_hold", InReady, 0);
    Enable = 1'b1;
    prev_rc = 0;
    for (int k = 0; k < 4; k++) begin
      issue(1, -1, 1'b0, rc);
      if (k > 0) chk("b2b_spacing", rc - prev_rc, 3);
      prev_rc = rc;
    end
    chk("b2b_inready", InReady, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b_empty_norun", Run, 0);
    end

    // Done while IDLE is ignored.
    Done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_done_count", IssueCount, model_cnt);
      chk("idle_done_busy", Busy, 0);
    end
    Done = 1'b0;

    // Timeout into HALT with words still queued.
    Enable = 1'b0;
    push(9'o600); push(9'o601); push(9'o602);
    Enable = 1'b1;
    wait_run(10, 1, ins, rc);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_wait_error", Error, 0);
      chk("to_wait_busy", Busy, 1);
    end
    tick();
    chk("to_error_set", Error, 1);
    chk("to_halt_busy", Busy, 0);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_norun", Run, 0);
      chk("halt_error", Error, 1);
      chk("halt_inready", InReady, 1);
      chk("halt_count", IssueCount, model_cnt);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_q.delete();
    model_cnt = 8'd0;
    chk("halt_rst_error", Error, 0);
    chk("halt_rst_busy", Busy, 0);
    chk("halt_rst_datain", DataIn, 0);
    chk("halt_rst_count", IssueCount, 0);
    chk("halt_rst_inready", InReady, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_rst_fifo_empty", Run, 0);
    end

    // Done in the 15th WAIT cycle wins over the timeout.
    push(9'o013);
    issue(15, 1, 1'b0, rc);
    chk("collide_error", Error, 0);

    // Reset during WAIT.
    push(9'o014);
    wait_run(10, 1, ins, rc);
    tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    model_cnt = 8'd0;
    chk("wait_rst_run", Run, 0);
    chk("wait_rst_busy", Busy, 0);
    chk("wait_rst_inready", InReady, 1);
    chk("wait_rst_count", IssueCount, 0);
    chk("wait_rst_error", Error, 0);

    // 256 completions wrap IssueCount back to zero.
    for (int k = 0; k < 256; k++) begin
      push({3'b010, 6'(k)});
      issue(1, 1, 1'b0, rc);
    end
    chk("wrap_zero", IssueCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/processor_instr_issuer.md
# processor_instr_issuer

Initiator-side feeder for the 9-bit processor: buffers 9-bit words from a host, then issues them one instruction at a time on the processor's DataIn/Run/Done interface. Each issue presents the instruction with a one-cycle Run pulse and supplies the immediate word for mvi. It then waits for Done before issuing the next instruction. The block sits between the host/program source and the processor core, and it raises a sticky error if the core never answers.

## Interface
- DEPTH, 4: instruction FIFO depth in 9-bit words (power of two, ≥2)
- MVI_OPCODE, 3'b001: opcode (bits [8:6]) that carries a second immediate word
- TIMEOUT, 15: maximum WAIT cycles without Done before Error (1..255)
- clock  in  1  single rising-edge clock
- Reset  in  1  synchronous, active-high reset
- InValid  in  1  host word valid
- InWord  in  9  host word (instruction or immediate)
- InReady  out  1  FIFO can accept; equals !full
- Enable  in  1  permits starting a new instruction
- DataIn  out  9  word driven to the processor
- Run  out  1  one-cycle start pulse to the processor
- Done  in  1  processor completion
- Busy  out  1  instruction in flight (ISSUE or WAIT)
- IssueCount  out  8  completed instructions, wraps 255→0
- Error  out  1  sticky Done timeout

## Operation
- FIFO: a push occurs on InValid&&InReady. A pushed word is not poppable in the same cycle. Push and pop may occur in the same cycle when the FIFO is not full. Count width is clog2(DEPTH)+1.
- Head opcode = head[8:6]. An instruction is ready when count≥1 and the head is not mvi, or when count≥2 and the head is mvi.
- States:
  - IDLE: if Enable && ready, pop the head into the DataIn register and go to ISSUE. Otherwise hold.
  - ISSUE (one cycle): Run=1, DataIn=instruction. If the opcode is mvi, pop the next word into the DataIn register in this cycle. Go to WAIT.
  - WAIT: Run=0. DataIn holds the immediate for mvi or the instruction otherwise. The timer increments each cycle. If Done=1: IssueCount++, timer cleared, go to IDLE. Else if timer==TIMEOUT-1: Error=1, go to HALT.
  - HALT: Run=0 and no pops; InReady still follows !full. Only Reset exits HALT.
- Done is sampled only in WAIT and is ignored in IDLE, ISSUE and HALT.
- Enable falling mid-instruction does not abort; the current instruction completes.
- Busy=1 in ISSUE and WAIT.

## Timing
- Reset value of every register: state IDLE, FIFO empty, DataIn=0, Run=0, Busy=0, IssueCount=0, Error=0, timer=0. InReady=1 in the cycle after Reset deasserts.
- Reset asserted mid-instruction or in HALT: the next cycle matches post-reset values. FIFO contents are discarded.
- Latency: push accepted at edge k into an empty FIFO with Enable=1 → Run=1 and DataIn=word in the cycle following edge k+1.
- Run pulse width is exactly one cycle. No back-to-back Run: there is at least one WAIT cycle plus one IDLE cycle between Run pulses.
- Done high at edge j while in WAIT → IDLE in cycle j. The next Run occurs at the earliest in cycle j+1 (edge j+1 → ISSUE).
- mvi immediate appears on DataIn in the first cycle after the Run cycle and holds until WAIT exits.
- Full FIFO: InReady=0 and InValid is ignored. The cycle after a pop, InReady=1.
- Error is set at the edge ending the TIMEOUT-th WAIT cycle without Done. Done arriving in that same cycle wins: no Error.

## Test plan
- Single instruction: push 9'o012 (opcode 000), Enable=1, Done 3 cycles after Run → one Run pulse with DataIn=9'o012, Busy for 4 cycles, IssueCount=1.
- mvi: push 9'o100 then 9'h0A5 → Run cycle DataIn=9'o100, following cycle DataIn=9'h0A5, held until Done. With only 9'o100 pushed, no Run is issued.
- Back-to-back: push 4 words (fills DEPTH=4) → InReady=0 after the 4th push. Processor answers Done 1 cycle after each Run → 4 Run pulses spaced 3 cycles apart, IssueCount=4, FIFO empty.
- Timeout: issue one instruction and never assert Done → Error=1 after 15 WAIT cycles, no further Run, stays in HALT with words still queued. Reset clears Error and the FIFO.
- Done collision: Done asserted in the 15th WAIT cycle → IssueCount increments, Error stays 0. Done pulses while IDLE have no effect.
- Reset mid-WAIT and IssueCount wrap: 256 completions → IssueCount=0. Reset during WAIT → Run=0, Busy=0, InReady=1 next cycle.
